token_bucket_mc: RTL

- Multi-channel successor of the single-channel token-bucket rate limiter.
- NUM_CH independent buckets, each with a runtime-programmable refill rate and burst cap.
- Each request carries its own cost.
- One shared grant per cycle, arbitrated round-robin among channels that can pay; sits in front of a shared downstream resource (bus port, DMA engine).

---
 rtl/token_bucket_pkg.sv | 32 +++
 rtl/tb_rr_arbiter.sv | 34 +++
 rtl/token_bucket_mc.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/token_bucket_pkg.sv
// Shared widths, defaults, config record and saturating helper for the
// multi-channel token-bucket rate limiter.
package token_bucket_pkg;

    localparam int NUM_CH_DEF   = 4;
    localparam int TOKEN_W_DEF  = 16;
    localparam int RATE_W_DEF   = 8;
    localparam int COST_W_DEF   = 8;
    localparam int DEN_DEF      = 16;
    localparam int DEF_RATE_DEF = 3;
    localparam int DEF_MAX_DEF  = 128;
    localparam int STAT_W       = 16;

    typedef struct packed {
        logic [RATE_W_DEF-1:0]  rate;
        logic [TOKEN_W_DEF-1:0] max;
    } tb_cfg_t;

    // min(a + b, cap) with a carry bit so the sum never wraps; callers zero-extend.
    function automatic logic [31:0] sat_add_min(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic [31:0] cap);
        logic [32:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s > {1'b0, cap}) begin
            return cap;
        end else begin
            return sum_s[31:0];
        end
    endfunction

endpackage

// File: rtl/tb_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after
// last_ptr, wrapping, so the last winner has lowest priority.
module tb_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_valid
);

    int cand_s;

    // Scan NUM_CH positions starting one past the previous winner.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand_s    = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand_s = (int'(last_ptr) + i) % NUM_CH;
            if (!gnt_valid && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                gnt_idx     = CH_W'(cand_s);
                gnt_valid   = 1'b1;
            end else begin
                gnt_idx = gnt_idx;
            end
        end
    end

endmodule

// File: rtl/token_bucket_mc.sv
// Multi-channel token-bucket rate limiter with a shared round-robin grant.
// Define TOKEN_BUCKET_MC_STATS_EN to add per-channel saturating stall counters.
module token_bucket_mc
    import token_bucket_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int TOKEN_W  = TOKEN_W_DEF,
    parameter int RATE_W   = RATE_W_DEF,
    parameter int COST_W   = COST_W_DEF,
    parameter int DEN      = DEN_DEF,
    parameter int DEF_RATE = DEF_RATE_DEF,
    parameter int DEF_MAX  = DEF_MAX_DEF,
    parameter int CH_W     = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we_i,
    input  logic [CH_W-1:0]           cfg_ch_i,
    input  logic [RATE_W-1:0]         cfg_rate_i,
    input  logic [TOKEN_W-1:0]        cfg_max_i,
`ifdef TOKEN_BUCKET_MC_STATS_EN
    input  logic                      stat_clr_i,
    output logic [NUM_CH*STAT_W-1:0]  stall_cnt_o,
`endif
    input  logic [NUM_CH-1:0]         req_valid_i,
    input  logic [NUM_CH*COST_W-1:0]  req_cost_i,
    output logic [NUM_CH-1:0]         grant_o,
    output logic [NUM_CH-1:0]         ready_o,
    output logic [NUM_CH*TOKEN_W-1:0] tokens_o
);

    if (NUM_CH < 2 || DEN < 1 || DEF_MAX >= (2 ** TOKEN_W)) begin : g_bad_params
        $error("token_bucket_mc: illegal parameter combination");
    end

    logic [TOKEN_W-1:0] tokens_r  [NUM_CH];
    logic [RATE_W-1:0]  rate_r    [NUM_CH];
    logic [TOKEN_W-1:0] max_r     [NUM_CH];
    logic [CH_W-1:0]    rr_ptr_r;

    logic [COST_W-1:0]  cost_s     [NUM_CH];
    logic [TOKEN_W-1:0] added_s    [NUM_CH];
    logic [TOKEN_W-1:0] paid_s     [NUM_CH];
    logic [TOKEN_W-1:0] next_tok_s [NUM_CH];
    logic [NUM_CH-1:0]  elig_s;
    logic [NUM_CH-1:0]  ready_s;
    logic [NUM_CH-1:0]  arb_gnt_s;
    logic [NUM_CH-1:0]  grant_s;
    logic [CH_W-1:0]    arb_idx_s;
    logic               arb_valid_s;
    logic               cfg_hit_s;

    // Refilled level, eligibility and ready view per channel.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cost_s[c]  = req_cost_i[c*COST_W +: COST_W];
            added_s[c] = TOKEN_W'(sat_add_min(32'(tokens_r[c]), 32'(rate_r[c]), 32'(max_r[c])));
            elig_s[c]  = req_valid_i[c] && (32'(added_s[c]) >= 32'(cost_s[c]));
            ready_s[c] = 32'(tokens_r[c]) >= 32'(cost_s[c]);
        end
    end

    tb_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req       (elig_s),
        .last_ptr  (rr_ptr_r),
        .gnt       (arb_gnt_s),
        .gnt_idx   (arb_idx_s),
        .gnt_valid (arb_valid_s)
    );

    // Reset must kill the grant without waiting for a clock.
    assign grant_s = arb_gnt_s & {NUM_CH{rst_n}};
    assign cfg_hit_s = cfg_we_i && (int'(cfg_ch_i) < NUM_CH);

    // Next bucket level: old config refill, deduct on grant, then clamp to a new cap.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_s[c]) begin
                paid_s[c] = added_s[c] - TOKEN_W'(cost_s[c]);
            end else begin
                paid_s[c] = added_s[c];
            end
            if (cfg_hit_s && (int'(cfg_ch_i) == c) && (paid_s[c] > cfg_max_i)) begin
                next_tok_s[c] = cfg_max_i;
            end else begin
                next_tok_s[c] = paid_s[c];
            end
        end
    end

    // Bucket levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tokens_r[c] <= TOKEN_W'(DEF_MAX);
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                tokens_r[c] <= next_tok_s[c];
            end
        end
    end

    // Per-channel rate and burst cap configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rate_r[c] <= RATE_W'(DEF_RATE);
                max_r[c]  <= TOKEN_W'(DEF_MAX);
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_hit_s && (int'(cfg_ch_i) == c)) begin
                    rate_r[c] <= cfg_rate_i;
                    max_r[c]  <= cfg_max_i;
                end
            end
        end
    end

    // Last granted channel; starts at the top so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= CH_W'(NUM_CH - 1);
        end else if (arb_valid_s) begin
            rr_ptr_r <= arb_idx_s;
        end
    end

    // Output packing.
    always_comb begin
        tokens_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            tokens_o[c*TOKEN_W +: TOKEN_W] = tokens_r[c];
        end
    end

    assign grant_o = grant_s;
    assign ready_o = ready_s;

`ifdef TOKEN_BUCKET_MC_STATS_EN
    logic [STAT_W-1:0] stall_r [NUM_CH];

    // Saturating count of cycles a channel waited with a request pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                stall_r[c] <= '0;
            end
        end else if (stat_clr_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                stall_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (req_valid_i[c] && !grant_s[c] && (stall_r[c] != {STAT_W{1'b1}})) begin
                    stall_r[c] <= stall_r[c] + STAT_W'(1);
                end
            end
        end
    end

    // Stall counter packing.
    always_comb begin
        stall_cnt_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            stall_cnt_o[c*STAT_W +: STAT_W] = stall_r[c];
        end
    end
`endif

endmodule
